// File: rtl/fcpu_pkg.sv
// Shared CPU-core widths and the CDB request record used by the result-bus arbiter.
package fcpu_pkg;

  localparam int RSV_ID_W = 6;
  localparam int DATA_W   = 32;
  localparam int CDB_W    = 38;

  // Consumers slice rsv_id at cdb[DATA_W +: RSV_ID_W], so the bus must pack exactly.
  localparam bit CDB_W_OK = (CDB_W == RSV_ID_W + DATA_W);

  typedef struct packed {
    logic [RSV_ID_W-1:0] rsv_id;
    logic [DATA_W-1:0]   data;
    logic                exception;
  } cdb_req_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter with a registered bus output and flush support.
// Optional per-requester statistics are enabled with `define CDB_ARB_STATS_EN.
module cdb_arbiter
  import fcpu_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_REQ-1:0]                   req_valid,
  output logic [N_REQ-1:0]                   req_ready,
  input  logic [N_REQ-1:0][RSV_ID_W-1:0]     req_rsv_id,
  input  logic [N_REQ-1:0][DATA_W-1:0]       req_data,
  input  logic [N_REQ-1:0]                   req_exception,
  input  logic                               clear,
  output logic                               cdb_valid,
  output logic                               cdb_exception,
  output logic [CDB_W-1:0]                   cdb
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][31:0]             stat_grants,
  output logic [31:0]                        stat_conflict
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (!CDB_W_OK) begin : g_width_chk
    $error("cdb_arbiter: CDB_W must equal RSV_ID_W + DATA_W");
  end

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic             cdb_exc_q;
  logic [CDB_W-1:0] cdb_q;

  logic [N_REQ-1:0] pick_grant;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;
  logic             take;
  cdb_req_t         sel;

  rr_pick #(.N(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Flush and reset both suppress acceptance outright, even with valids pending.
  assign take      = pick_any && !clear && !rst;
  assign req_ready = take ? pick_grant : '0;

  always_comb begin
    sel.rsv_id    = req_rsv_id[pick_idx];
    sel.data      = req_data[pick_idx];
    sel.exception = req_exception[pick_idx];

    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = take;
    if (clear) begin
      rr_ptr_d = '0;
    end else if (take) begin
      rr_ptr_d = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_exc_q   <= 1'b0;
      cdb_q       <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      if (take) begin
        cdb_q     <= {sel.rsv_id, sel.data};
        cdb_exc_q <= sel.exception;
      end
    end
  end

  assign cdb_valid     = cdb_valid_q;
  assign cdb_exception = cdb_exc_q;
  assign cdb           = cdb_q;

`ifdef CDB_ARB_STATS_EN
  logic [N_REQ-1:0][31:0] grants_q;
  logic [31:0]            conflict_q;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant_cnt
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        grants_q[gi] <= '0;
      end else if (req_valid[gi] && req_ready[gi]) begin
        grants_q[gi] <= grants_q[gi] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= '0;
    end else if (!clear && ($countones(req_valid) >= 2)) begin
      conflict_q <= conflict_q + 32'd1;
    end
  end

  assign stat_grants   = grants_q;
  assign stat_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus queues expected bus beats, a negedge monitor checks them.
module tb_cdb_arbiter;
  import fcpu_pkg::*;

  localparam int N = 4;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [N-1:0]                  req_valid;
  logic [N-1:0]                  req_ready;
  logic [N-1:0][RSV_ID_W-1:0]    req_rsv_id;
  logic [N-1:0][DATA_W-1:0]      req_data;
  logic [N-1:0]                  req_exception;
  logic                          clear;
  logic                          cdb_valid;
  logic                          cdb_exception;
  logic [CDB_W-1:0]              cdb;
`ifdef CDB_ARB_STATS_EN
  logic [N-1:0][31:0]            stat_grants;
  logic [31:0]                   stat_conflict;
`endif

  cdb_arbiter #(.N_REQ(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rsv_id    (req_rsv_id),
    .req_data      (req_data),
    .req_exception (req_exception),
    .clear         (clear),
    .cdb_valid     (cdb_valid),
    .cdb_exception (cdb_exception),
    .cdb           (cdb)
`ifdef CDB_ARB_STATS_EN
    ,
    .stat_grants   (stat_grants),
    .stat_conflict (stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CDB_W-1:0] cdb;
    logic             exc;
    int               due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
  endtask

  // Queue the bus beat the hand-computed grant should produce on the following cycle.
  task automatic push_exp(input logic [N-1:0] onehot);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) begin
        e.cdb = {req_rsv_id[i], req_data[i]};
        e.exc = req_exception[i];
      end
    end
    e.due = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [N-1:0] v, input logic c, input logic [N-1:0] exp_rdy, input string nm);
    @(negedge clk);
    req_valid = v;
    clear     = c;
    #1;
    chk(nm, 64'(req_ready), 64'(exp_rdy));
    $display("step %-12s valid=%b clear=%b ready=%b", nm, v, c, req_ready);
    if (exp_rdy != '0) push_exp(exp_rdy);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_valid", 64'(cdb_valid), 64'd1);
        chk("mon_cdb", 64'(cdb), 64'(e.cdb));
        chk("mon_exc", 64'(cdb_exception), 64'(e.exc));
        $display("bus  cyc=%0d rsv_id=%0d data=%h exc=%b", cyc, cdb[DATA_W +: RSV_ID_W], cdb[DATA_W-1:0], cdb_exception);
      end else begin
        chk("mon_idle", 64'(cdb_valid), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    clear         = 1'b0;
    req_valid     = 4'b1111;
    req_exception = '0;
    for (int i = 0; i < N; i++) begin
      req_rsv_id[i] = RSV_ID_W'(10 + i);
      req_data[i]   = 32'hC0DE_0000 + 32'(i);
    end
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb", 64'(cdb), 64'd0);
    chk("rst_exc", 64'(cdb_exception), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;

    // Single requester
    req_rsv_id[1] = RSV_ID_W'(5);
    req_data[1]   = 32'h0000_DEAD;
    step(4'b0010, 1'b0, 4'b0010, "t1_single");
    step(4'b0000, 1'b0, 4'b0000, "t1_idle");

    // Pointer sits at 2: wrap to unit 0, then unit 1
    step(4'b0011, 1'b0, 4'b0001, "t3_skip0");
    step(4'b0011, 1'b0, 4'b0010, "t3_skip1");

    // Clear resets the pointer, then all four rotate with no bus gaps
    step(4'b0000, 1'b1, 4'b0000, "t2_clr");
    req_exception = 4'b0100;
    step(4'b1111, 1'b0, 4'b0001, "t2_g0");
    step(4'b1111, 1'b0, 4'b0010, "t2_g1");
    step(4'b1111, 1'b0, 4'b0100, "t2_g2");
    step(4'b1111, 1'b0, 4'b1000, "t2_g3");
    step(4'b1111, 1'b0, 4'b0001, "t2_g0b");
    req_exception = '0;

    // Flush while unit 3's result is on the bus
    step(4'b1000, 1'b0, 4'b1000, "t4_g3");
    step(4'b1111, 1'b1, 4'b0000, "t4_clear");
    step(4'b0000, 1'b0, 4'b0000, "t4_post");
    step(4'b1111, 1'b0, 4'b0001, "t4_ptr0");

    // Async reset while the bus is valid
    step(4'b0100, 1'b0, 4'b0100, "t5_g2");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_valid", 64'(cdb_valid), 64'd0);
    chk("t5_async_cdb", 64'(cdb), 64'd0);
    chk("t5_async_exc", 64'(cdb_exception), 64'd0);
    req_valid = 4'b1111;
    #1;
    chk("t5_rst_ready", 64'(req_ready), 64'd0);
    $display("step t5_async   rst asserted, valid=%b ready=%b", cdb_valid, req_ready);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_rst_hold", 64'(cdb_valid), 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    step(4'b0110, 1'b0, 4'b0010, "t5_after");
    step(4'b0000, 1'b0, 4'b0000, "t5_idle");

`ifdef CDB_ARB_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(4'b0101, 1'b0, (i % 2 == 0) ? 4'b0001 : 4'b0100, "t6_alt");
    end
    step(4'b0000, 1'b0, 4'b0000, "t6_idle");
    chk("t6_grants0", 64'(stat_grants[0]), 64'd5);
    chk("t6_grants2", 64'(stat_grants[2]), 64'd5);
    chk("t6_conflict", 64'(stat_conflict), 64'd10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_g0", 64'(stat_grants[0]), 64'd0);
    chk("t6_rst_g2", 64'(stat_grants[2]), 64'd0);
    chk("t6_rst_conf", 64'(stat_conflict), 64'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    repeat (3) @(negedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
